// File: rtl/serializer_pkg.sv
// Definitions shared by the serializer and deserializer: default widths,
// the collector state encoding and the bit-count type.
package serializer_pkg;

  localparam int DEF_DATA_BUS_WIDTH = 16;
  localparam int DEF_DATA_MOD_WIDTH = $clog2(DEF_DATA_BUS_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef logic [DEF_DATA_MOD_WIDTH-1:0] mod_t;

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register; a new word loads when empty or draining.
// Under backpressure a new word is dropped, the held word is kept and ovf_o pulses.
module deser_out_buf #(
  parameter int WIDTH = 20
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_dat_o,
  input  logic             out_rdy_i,
  output logic             ovf_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             ovf_q, ovf_d;
  logic             load;

  always_comb begin
    load  = in_vld_i && (!vld_q || out_rdy_i);
    vld_d = vld_q;
    dat_d = dat_q;
    ovf_d = in_vld_i && vld_q && !out_rdy_i;
    if (load) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/deserializer.sv
// Collects an MSB-first serial stream into words closed by a full count or a valid drop,
// then hands them to a one-entry holding register with overflow reporting.
module deserializer #(
  parameter int DATA_BUS_WIDTH = serializer_pkg::DEF_DATA_BUS_WIDTH,
  parameter int DATA_MOD_WIDTH = serializer_pkg::DEF_DATA_MOD_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_mod_o,
  output logic                      deser_data_val_o,
  input  logic                      deser_ready_i,
  output logic                      overflow_o
);

  import serializer_pkg::*;

  localparam int            CW       = DATA_MOD_WIDTH + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BUS_WIDTH - 1);

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d, shift_fill;
  logic                      close;
  logic [DATA_BUS_WIDTH-1:0] close_dat;
  logic [DATA_MOD_WIDTH-1:0] close_mod;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    close      = 1'b0;
    close_dat  = shift_q;
    close_mod  = cnt_q[DATA_MOD_WIDTH-1:0];
    // Bit k lands at position W-1-k; unfilled positions stay zero.
    shift_fill = shift_q | ({ser_data_i, {(DATA_BUS_WIDTH-1){1'b0}}} >> cnt_q);
    if (ser_data_val_i) begin
      if (cnt_q == LAST_CNT) begin
        close     = 1'b1;
        close_dat = shift_fill;
        close_mod = '0;
        cnt_d     = '0;
        shift_d   = '0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        shift_d = shift_fill;
      end
    end else if (cnt_q != '0) begin
      close   = 1'b1;
      cnt_d   = '0;
      shift_d = '0;
    end

    case (state_q)
      IDLE:    if (ser_data_val_i) state_d = SHIFT;
      SHIFT:   if (close && !ser_data_val_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  deser_out_buf #(
    .WIDTH(DATA_MOD_WIDTH + DATA_BUS_WIDTH)
  ) u_out_buf (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .in_vld_i  (close),
    .in_dat_i  ({close_mod, close_dat}),
    .out_vld_o (deser_data_val_o),
    .out_dat_o ({deser_mod_o, deser_data_o}),
    .out_rdy_i (deser_ready_i),
    .ovf_o     (overflow_o)
  );

endmodule

// File: tb/tb_deserializer.sv
// Randomized and directed bench for deserializer, checked each cycle against a
// queue-based word model plus literal expectations for the directed cases.
module tb_deserializer;

  localparam int W  = 16;
  localparam int MW = 4;

  logic          clk     = 1'b0;
  logic          arst_n  = 1'b0;
  logic          ser     = 1'b0;
  logic          ser_val = 1'b0;
  logic          rdy     = 1'b0;
  logic [W-1:0]  dout;
  logic [MW-1:0] mod;
  logic          dval;
  logic          ovf;

  int checks   = 0;
  int errors   = 0;
  int cyc_cnt  = 0;
  int ovf_seen = 0;

  logic [MW+W-1:0] obs_w[$];
  int              obs_c[$];

  always #5 clk = ~clk;

  deserializer #(
    .DATA_BUS_WIDTH(W),
    .DATA_MOD_WIDTH(MW)
  ) dut (
    .clk_i            (clk),
    .arst_ni          (arst_n),
    .ser_data_i       (ser),
    .ser_data_val_i   (ser_val),
    .deser_data_o     (dout),
    .deser_mod_o      (mod),
    .deser_data_val_o (dval),
    .deser_ready_i    (rdy),
    .overflow_o       (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Model: bits pile up in a list; a word is the list packed MSB-first.
  bit            pend[$];
  logic [W-1:0]  m_dat;
  logic [MW-1:0] m_mod;
  logic          m_vld;
  logic          m_ovf;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pend.delete();
      m_dat = '0;
      m_mod = '0;
      m_vld = 1'b0;
      m_ovf = 1'b0;
    end else begin
      bit           got;
      logic [W-1:0] w;
      int           n;
      got = 1'b0;
      w   = '0;
      n   = 0;
      if (ser_val) begin
        pend.push_back(ser);
        got = (pend.size() == W);
      end else begin
        got = (pend.size() > 0);
      end
      if (got) begin
        n = pend.size();
        for (int i = 0; i < n; i++) w[W-1-i] = pend[i];
        pend.delete();
      end
      m_ovf = 1'b0;
      if (got && m_vld && !rdy) begin
        m_ovf = 1'b1;
      end else if (got) begin
        m_vld = 1'b1;
        m_dat = w;
        m_mod = MW'(n % W);
      end else if (rdy) begin
        m_vld = 1'b0;
      end
    end
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    chk("data", dout, m_dat);
    chk("mod", mod, m_mod);
    chk("valid", dval, m_vld);
    chk("overflow", ovf, m_ovf);
    if (arst_n && dval && rdy) begin
      obs_w.push_back({mod, dout});
      obs_c.push_back(cyc_cnt);
    end
    if (ovf) ovf_seen++;
  end

  task automatic cyc(input logic v, input logic b);
    ser_val = v;
    ser     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int from, input int n);
    for (int i = from; i < from + n; i++) cyc(1'b1, w[W-1-i]);
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", dval, 1'b0);
    chk("rst_data", dout, 16'h0000);
    chk("rst_mod", mod, 4'd0);
    chk("rst_ovf", ovf, 1'b0);
    arst_n = 1'b1;
    cyc(1'b0, 1'b0);

    // Full word, ready high
    rdy = 1'b1;
    send_bits(16'hA5C3, 0, 15);
    chk("full_not_early", dval, 1'b0);
    send_bits(16'hA5C3, 15, 1);
    chk("full_valid", dval, 1'b1);
    chk("full_data", dout, 16'hA5C3);
    chk("full_mod", mod, 4'd0);
    cyc(1'b0, 1'b0);
    chk("full_drained", dval, 1'b0);

    // Partial word 1,0,1,1,0
    send_bits(16'hB000, 0, 5);
    chk("part_not_early", dval, 1'b0);
    cyc(1'b0, 1'b0);
    chk("part_valid", dval, 1'b1);
    chk("part_data", dout, 16'hB000);
    chk("part_mod", mod, 4'd5);
    cyc(1'b0, 1'b0);
    chk("part_drained", dval, 1'b0);

    // Back-to-back full words
    obs_w.delete();
    obs_c.delete();
    send_bits(16'h1234, 0, 16);
    send_bits(16'hFFFF, 0, 16);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("b2b_count", obs_w.size(), 2);
    if (obs_w.size() == 2) begin
      chk("b2b_word0", obs_w[0], {4'd0, 16'h1234});
      chk("b2b_word1", obs_w[1], {4'd0, 16'hFFFF});
      chk("b2b_spacing", obs_c[1] - obs_c[0], 16);
    end

    // Backpressure: words 2 and 3 dropped
    rdy  = 1'b0;
    base = ovf_seen;
    obs_w.delete();
    send_bits(16'h0001, 0, 16);
    send_bits(16'h2222, 0, 16);
    send_bits(16'h3333, 0, 16);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("bp_held_valid", dval, 1'b1);
    chk("bp_held_data", dout, 16'h0001);
    chk("bp_ovf_pulses", ovf_seen - base, 2);
    rdy = 1'b1;
    cyc(1'b0, 1'b0);
    chk("bp_delivered_count", obs_w.size(), 1);
    if (obs_w.size() == 1) chk("bp_delivered_word", obs_w[0], {4'd0, 16'h0001});
    chk("bp_drained", dval, 1'b0);

    // Reset mid-word with a held word
    rdy = 1'b0;
    send_bits(16'h5A5A, 0, 16);
    send_bits(16'hFFFF, 0, 7);
    #3;
    arst_n = 1'b0;
    #1;
    chk("rst_mid_valid", dval, 1'b0);
    chk("rst_mid_data", dout, 16'h0000);
    chk("rst_mid_ovf", ovf, 1'b0);
    ser_val = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    rdy    = 1'b1;
    base   = ovf_seen;
    obs_w.delete();
    cyc(1'b0, 1'b0);
    send_bits(16'h00FF, 0, 16);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("rst_after_count", obs_w.size(), 1);
    if (obs_w.size() == 1) chk("rst_after_word", obs_w[0], {4'd0, 16'h00FF});
    chk("rst_after_ovf", ovf_seen - base, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      cyc(($urandom_range(0, 9) < 8), 1'($urandom));
    end
    rdy = 1'b1;
    repeat (4) cyc(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
